// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: sequencer for the shared multiply/divide unit and the HI/LO pair.
// An accepted MULT/MULTU/MSUB or DIV/DIVU latches its operands and then counts a
// fixed latency. While it counts, busy_o is high. On the edge where busy_o falls,
// the result computed from the latched operands is written into HI/LO.
// MTHI/MTLO write HI/LO directly, and only while the unit is idle.
module md_unit_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MSUB  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // The counter is loaded with N-1 on acceptance, so busy_o stays high for exactly N cycles.
    localparam logic [3:0] LP_MUL_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] LP_DIV_LOAD = 4'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN_MUL = 2'd1,
        ST_RUN_DIV = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_md_class;
    logic [63:0] w_prod_signed;
    logic [63:0] w_prod_unsigned;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_dq;
    logic [31:0] w_dr;
    logic [63:0] w_result;

    // Two's-complement magnitude. 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] f_mag(input logic [31:0] v);
        f_mag = v[31] ? (32'd0 - v) : v;
    endfunction

    // Applies a sign to an unsigned magnitude by conditional negation.
    function automatic logic [31:0] f_apply_sign(input logic [31:0] v, input logic neg);
        f_apply_sign = neg ? (32'd0 - v) : v;
    endfunction

    // Ops 0..4 occupy the shared unit and therefore stall the pipe.
    assign w_md_class = (op_i == OP_MULT) || (op_i == OP_MULTU) || (op_i == OP_DIV) ||
                        (op_i == OP_DIVU) || (op_i == OP_MSUB);

    // The low 64 bits of a sign-extended product equal the signed 32x32 product.
    assign w_prod_signed   = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_unsigned = {32'd0, r_a} * {32'd0, r_b};

    // Signed division is done on magnitudes, and the signs are restored afterwards.
    // The quotient is truncated toward zero, and the remainder takes the sign of the dividend.
    // 0x80000000 / -1 falls out naturally: the quotient is 0x80000000 and the remainder is 0.
    assign w_a_mag = f_mag(r_a);
    assign w_b_mag = f_mag(r_b);

    // Magnitude divider; a zero divisor is steered away so the result stays well defined.
    always_comb begin
        w_uq = 32'd0;
        w_ur = 32'd0;
        w_dq = 32'd0;
        w_dr = 32'd0;
        if (r_b != 32'd0) begin
            w_uq = w_a_mag / w_b_mag;
            w_ur = w_a_mag % w_b_mag;
            w_dq = r_a / r_b;
            w_dr = r_a % r_b;
        end else begin
            w_uq = 32'd0;
            w_ur = 32'd0;
            w_dq = 32'd0;
            w_dr = 32'd0;
        end
    end

    assign w_sq = f_apply_sign(w_uq, r_a[31] ^ r_b[31]);
    assign w_sr = f_apply_sign(w_ur, r_a[31]);

    // Selects the {HI,LO} value committed when the latency counter expires.
    always_comb begin
        w_result = {r_hi, r_lo};
        case (r_op)
            OP_MULT:  w_result = w_prod_signed;
            OP_MULTU: w_result = w_prod_unsigned;
            OP_MSUB:  w_result = {r_hi, r_lo} - w_prod_signed;
            OP_DIV: begin
                if (r_b == 32'd0) begin
                    w_result = {r_a, 32'hFFFF_FFFF};
                end else begin
                    w_result = {w_sr, w_sq};
                end
            end
            OP_DIVU: begin
                if (r_b == 32'd0) begin
                    w_result = {r_a, 32'hFFFF_FFFF};
                end else begin
                    w_result = {w_dr, w_dq};
                end
            end
            default:  w_result = {r_hi, r_lo};
        endcase
    end

    // Sequencer FSM: accepts ops in IDLE, counts the latency, and commits HI/LO on expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_op    <= 3'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        case (op_i)
                            OP_MULT, OP_MULTU, OP_MSUB: begin
                                r_state <= ST_RUN_MUL;
                                r_cnt   <= LP_MUL_LOAD;
                                r_busy  <= 1'b1;
                                r_op    <= op_i;
                                r_a     <= a_i;
                                r_b     <= b_i;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_state <= ST_RUN_DIV;
                                r_cnt   <= LP_DIV_LOAD;
                                r_busy  <= 1'b1;
                                r_op    <= op_i;
                                r_a     <= a_i;
                                r_b     <= b_i;
                            end
                            OP_MTHI: r_hi <= a_i;
                            OP_MTLO: r_lo <= a_i;
                            default: r_state <= ST_IDLE;
                        endcase
                    end
                end
                ST_RUN_MUL, ST_RUN_DIV: begin
                    // New requests are ignored here; only the counter moves.
                    if (r_cnt == 4'd0) begin
                        r_hi    <= w_result[63:32];
                        r_lo    <= w_result[31:0];
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign busy_o  = r_busy;
    assign stall_o = r_busy | (start_i & w_md_class);
    assign hi_o    = r_hi;
    assign lo_o    = r_lo;

endmodule
